mem_sram_controller: RTL and testbench

Sequences MEM-stage data accesses onto a 16-bit single-port external SRAM with programmable wait states. Each 32-bit word access is split into two halfword phases. While a transaction is in flight the controller drops `ready`, and the pipeline freezes on `~ready`. The controller sits between the MEM stage and the SRAM pins and keeps the data-memory map: base byte address 1024, big-endian word layout.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/sram_phase_counter.sv | 35 +++
 rtl/mem_sram_controller.sv | 126 ++++++++++++
 tb/tb_mem_sram_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM-stage SRAM controller: FSM states, op encoding and
// the default data-memory base address.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam int unsigned MEM_BASE_DEFAULT = 1024;

endpackage

// File: rtl/sram_phase_counter.sv
// Per-phase cycle counter: runs 0..PHASE_CYCLES-1 while enabled, wraps to 0 on
// the last cycle, and exposes its next value so callers can register outputs.
module sram_phase_counter #(
   parameter int unsigned PHASE_CYCLES = 3,
   localparam int unsigned CW = $clog2(PHASE_CYCLES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_nx,
   output logic          last
);

   assign last = (count == CW'(PHASE_CYCLES - 1));

   always_comb begin
      count_nx = count;
      if (clr) begin
         count_nx = '0;
      end else if (en) begin
         count_nx = last ? '0 : count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= count_nx;
      end
   end

endmodule

// File: rtl/mem_sram_controller.sv
// Splits 32-bit MEM-stage accesses into big-endian hi/lo halfword phases on a
// 16-bit single-port SRAM; ready drops for the whole transaction.
//
// state | meaning
// IDLE  | no transaction; a request is latched and ready drops combinationally
// HI    | halfword {w,0}, data[31:16], PHASE_CYCLES cycles
// LO    | halfword {w,1}, data[15:0], PHASE_CYCLES cycles
// DONE  | one cycle, ready=1, read data valid on data_out
module mem_sram_controller
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned SRAM_AW      = 18,
   parameter int unsigned PHASE_CYCLES = 3,
   parameter int unsigned MEM_BASE     = MEM_BASE_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_w_en,
   input  logic               MEM_r_en,
   input  logic [31:0]        address,
   input  logic [31:0]        data_in,
   output logic [31:0]        data_out,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int unsigned CW = $clog2(PHASE_CYCLES + 1);
   localparam int unsigned WW = SRAM_AW - 1;

   state_t             state, state_nx;
   op_t                op_q, op_nx;
   logic [WW-1:0]      w_q, w_nx, w_in;
   logic [31:0]        wdata_q, wdata_nx, offs;
   logic [15:0]        rbuf_hi;
   logic [CW-1:0]      cnt, cnt_nx;
   logic               last, busy, busy_nx, wr_nx, req;
   logic [SRAM_AW-1:0] addr_nx;
   logic [15:0]        dq_nx;
   logic               oe_nx, we_n_nx;
   logic               unused_offs;

   assign req         = MEM_w_en | MEM_r_en;
   assign offs        = address - 32'(MEM_BASE);
   assign w_in        = offs[WW+1:2];
   assign unused_offs = ^{offs[31:WW+2], offs[1:0]};
   assign busy        = (state == HI) || (state == LO);

   sram_phase_counter #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (!busy),
      .en       (busy),
      .count    (cnt),
      .count_nx (cnt_nx),
      .last     (last)
   );

   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      op_nx    = op_q;
      w_nx     = w_q;
      wdata_nx = wdata_q;
      case (state)
         IDLE: begin
            ready = ~req;
            if (req) begin
               state_nx = HI;
               op_nx    = MEM_w_en ? OP_WR : OP_RD;
               w_nx     = w_in;
               wdata_nx = data_in;
            end
         end
         HI:      if (last) state_nx = LO;
         LO:      if (last) state_nx = DONE;
         DONE: begin
            ready    = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Pins are registered from next-state so they are glitch-free and the
      // write strobe releases one cycle before the phase ends (hold time).
      busy_nx = (state_nx == HI) || (state_nx == LO);
      wr_nx   = busy_nx && (op_nx == OP_WR);
      addr_nx = busy_nx ? {w_nx, (state_nx == LO)} : sram_addr;
      dq_nx   = wr_nx ? ((state_nx == LO) ? wdata_nx[15:0] : wdata_nx[31:16])
                      : sram_dq_out;
      oe_nx   = wr_nx;
      we_n_nx = !(wr_nx && ((cnt_nx != CW'(PHASE_CYCLES - 1)) || (PHASE_CYCLES == 1)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= OP_RD;
         w_q         <= '0;
         wdata_q     <= '0;
         rbuf_hi     <= '0;
         data_out    <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         state       <= state_nx;
         op_q        <= op_nx;
         w_q         <= w_nx;
         wdata_q     <= wdata_nx;
         sram_addr   <= addr_nx;
         sram_dq_out <= dq_nx;
         sram_dq_oe  <= oe_nx;
         sram_we_n   <= we_n_nx;
         if ((op_q == OP_RD) && last) begin
            if (state == HI) rbuf_hi <= sram_dq_in;
            if (state == LO) data_out <= {rbuf_hi, sram_dq_in};
         end
      end
   end

endmodule

// File: tb/tb_mem_sram_controller.sv
// Bench for mem_sram_controller: table of transactions plus reset/back-to-back
// sequences, with a small SRAM model and a queue of expected data_out values.
module tb_mem_sram_controller;

   localparam int SRAM_AW = 18;

   logic               clk = 1'b0;
   logic               rst;
   logic               w_en, r_en;
   logic [31:0]        address, data_in, data_out;
   logic               ready;
   logic [SRAM_AW-1:0] sram_addr;
   logic [15:0]        sram_dq_out, sram_dq_in;
   logic               sram_dq_oe, sram_we_n;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hi_start = 0;
   int done_cyc = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      logic        scr;
   } vec_t;
   vec_t vecs[6];

   mem_sram_controller #(.SRAM_AW(SRAM_AW), .PHASE_CYCLES(3), .MEM_BASE(1024)) dut (
      .clk         (clk),
      .rst         (rst),
      .MEM_w_en    (w_en),
      .MEM_r_en    (r_en),
      .address     (address),
      .data_in     (data_in),
      .data_out    (data_out),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_we_n   (sram_we_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: a write commits only when we_n rises while data is still driven.
   logic [15:0] sram_mem [0:255] = '{default: 16'h0000};
   logic        we_n_prev = 1'b1;
   assign sram_dq_in = sram_mem[sram_addr[7:0]];
   always @(negedge clk) begin
      if (!we_n_prev && sram_we_n && sram_dq_oe) sram_mem[sram_addr[7:0]] <= sram_dq_out;
      we_n_prev <= sram_we_n;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Follows one transaction from its IDLE request cycle to DONE.
   task automatic run_txn(input logic is_wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic scr);
      logic [31:0] off;
      logic [16:0] w;
      logic [31:0] exp;
      int          k = 0;
      bit          done = 0;
      off = addr - 32'd1024;
      w   = off[18:2];
      for (int g = 0; g < 40 && !done; g++) begin
         @(negedge clk);
         k++;
         if (ready) begin
            done = 1;
         end else if (k == 1) begin
            check("idle_oe", 32'(sram_dq_oe), 32'd0);
            check("idle_we_n", 32'(sram_we_n), 32'd1);
         end else begin
            int   p;
            logic lo;
            p  = (k - 2) % 3;
            lo = (k >= 5);
            if (k == 2) hi_start = cyc;
            if (scr && k == 2) begin
               address = $urandom();
               data_in = $urandom();
            end
            check("sram_addr", 32'(sram_addr), 32'({w, lo}));
            if (is_wr) begin
               check("wr_oe", 32'(sram_dq_oe), 32'd1);
               check("wr_we_n", 32'(sram_we_n), 32'(p == 2));
               check("wr_dq", 32'(sram_dq_out), 32'(lo ? wdata[15:0] : wdata[31:16]));
            end else begin
               check("rd_oe", 32'(sram_dq_oe), 32'd0);
               check("rd_we_n", 32'(sram_we_n), 32'd1);
            end
         end
      end
      if (!done) begin
         check("ready_timeout", 32'd0, 32'd1);
      end else begin
         done_cyc = cyc;
         check("ready_low_cycles", 32'(k - 1), 32'd7);
         check("done_oe", 32'(sram_dq_oe), 32'd0);
         check("done_we_n", 32'(sram_we_n), 32'd1);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
         check("data_out", data_out, exp);
      end
   endtask

   task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      w_en = w;
      r_en = r;
      address = a;
      data_in = d;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0402, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_0408, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0408, 32'h0000_0000, 32'h1234_5678, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 32'h0008_0400, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_040C, 32'h1111_5A5A, 32'hDEAD_BEEF, 1'b0};

      rst = 1'b1; w_en = 1'b0; r_en = 1'b1; address = 32'h400; data_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_data_out", data_out, 32'd0);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_sram_addr", 32'(sram_addr), 32'd0);
      check("rst_ready_with_req", 32'(ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.push_back(32'h0000_0000);
      run_txn(1'b0, 32'h400, 32'h0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].wdata);
         exp_q.push_back(vecs[i].exp);
         run_txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].scr);
      end
      check("mem_hw4", 32'(sram_mem[4]), 32'h1234);
      check("mem_hw5", 32'(sram_mem[5]), 32'h5678);

      // Reset in the first LO cycle of a write: only the hi half lands.
      drive(1'b1, 1'b0, 32'h40C, 32'hCAFE_F00D);
      repeat (5) @(negedge clk);
      check("abort_lo_addr", 32'(sram_addr), 32'd7);
      check("abort_lo_we_n", 32'(sram_we_n), 32'd0);
      rst = 1'b1; w_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_we_n", 32'(sram_we_n), 32'd1);
      check("abort_oe", 32'(sram_dq_oe), 32'd0);
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_data_out", data_out, 32'd0);
      check("abort_hw6", 32'(sram_mem[6]), 32'hCAFE);
      check("abort_hw7", 32'(sram_mem[7]), 32'h5A5A);
      drive(1'b0, 1'b1, 32'h40C, 32'h0);
      exp_q.push_back(32'hCAFE_5A5A);
      run_txn(1'b0, 32'h40C, 32'h0, 1'b0);

      // Back-to-back read then write with requests held continuously.
      drive(1'b0, 1'b1, 32'h400, 32'h0);
      exp_q.push_back(32'hDEAD_BEEF);
      run_txn(1'b0, 32'h400, 32'h0, 1'b0);
      begin
         int d1;
         d1 = done_cyc;
         drive(1'b1, 1'b0, 32'h404, 32'h0BAD_C0DE);
         exp_q.push_back(32'hDEAD_BEEF);
         run_txn(1'b1, 32'h404, 32'h0BAD_C0DE, 1'b0);
         check("b2b_hi_gap", 32'(hi_start - d1), 32'd2);
      end

      drive(1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_ready", 32'(ready), 32'd1);
         check("idle_hold_data_out", data_out, 32'hDEAD_BEEF);
         check("idle_oe_off", 32'(sram_dq_oe), 32'd0);
      end
      drive(1'b0, 1'b1, 32'h404, 32'h0);
      exp_q.push_back(32'h0BAD_C0DE);
      run_txn(1'b0, 32'h404, 32'h0, 1'b0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
